// File: rtl/a25_copro_initiator.sv
// a25_copro_initiator
// Turns a core-side request (MCR/MRC) into a coprocessor 15 operation and
// returns a single response. Requests that target any other coprocessor
// number are answered directly with an error and never reach the coprocessor.
// Reads take one extra CAPTURE cycle, because the coprocessor read register
// only holds data for the addressed crn one edge after the issue.

module a25_copro_initiator (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_core_stall,

  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [3:0]  i_req_num,
  input  logic [3:0]  i_req_crn,
  input  logic [3:0]  i_req_crm,
  input  logic [2:0]  i_req_opcode1,
  input  logic [2:0]  i_req_opcode2,
  input  logic [31:0] i_req_wdata,

  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,

  output logic [1:0]  o_copro_operation,
  output logic [3:0]  o_copro_num,
  output logic [3:0]  o_copro_crn,
  output logic [3:0]  o_copro_crm,
  output logic [2:0]  o_copro_opcode1,
  output logic [2:0]  o_copro_opcode2,
  output logic [31:0] o_copro_write_data,
  input  logic [31:0] i_copro_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_IDLE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [3:0] CP15 = 4'd15;

  state_t      state_q;
  logic        write_q;
  logic [1:0]  op_q;
  logic [3:0]  num_q;
  logic [3:0]  crn_q;
  logic [3:0]  crm_q;
  logic [2:0]  opcode1_q;
  logic [2:0]  opcode2_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        rsp_valid_q;
  logic        req_ready_q;

  // Request/response state machine; every output comes straight from a register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      op_q        <= OP_IDLE;
      num_q       <= 4'd0;
      crn_q       <= 4'd0;
      crm_q       <= 4'd0;
      opcode1_q   <= 3'd0;
      opcode2_q   <= 3'd0;
      wdata_q     <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            write_q     <= i_req_write;
            num_q       <= i_req_num;
            crn_q       <= i_req_crn;
            crm_q       <= i_req_crm;
            opcode1_q   <= i_req_opcode1;
            opcode2_q   <= i_req_opcode2;
            wdata_q     <= i_req_wdata;
            req_ready_q <= 1'b0;
            if (i_req_num == CP15) begin
              op_q    <= i_req_write ? OP_WRITE : OP_READ;
              state_q <= ISSUE;
            end else begin
              rdata_q     <= 32'd0;
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end

        ISSUE: begin
          if (!i_core_stall) begin
            op_q <= OP_IDLE;
            if (write_q) begin
              rdata_q     <= 32'd0;
              err_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          rdata_q     <= i_copro_read_data;
          err_q       <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end

        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          op_q        <= OP_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready        = req_ready_q;
  assign o_rsp_valid        = rsp_valid_q;
  assign o_rsp_rdata        = rdata_q;
  assign o_rsp_err          = err_q;
  assign o_copro_operation  = op_q;
  assign o_copro_num        = num_q;
  assign o_copro_crn        = crn_q;
  assign o_copro_crm        = crm_q;
  assign o_copro_opcode1    = opcode1_q;
  assign o_copro_opcode2    = opcode2_q;
  assign o_copro_write_data = wdata_q;

endmodule

// File: tb/tb_a25_copro_initiator.sv
// tb_a25_copro_initiator
// Directed scenarios for the coprocessor initiator: reset, write, read,
// stalled issue, bad coprocessor number, response backpressure and reset
// during a stalled issue. A small coprocessor register model supplies reads.

module tb_a25_copro_initiator;

  logic        clk;
  logic        rstN;
  logic        coreStall;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [3:0]  reqNum;
  logic [3:0]  reqCrn;
  logic [3:0]  reqCrm;
  logic [2:0]  reqOp1;
  logic [2:0]  reqOp2;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [1:0]  copOp;
  logic [3:0]  copNum;
  logic [3:0]  copCrn;
  logic [3:0]  copCrm;
  logic [2:0]  copOp1;
  logic [2:0]  copOp2;
  logic [31:0] copWdata;
  logic [31:0] copRdata;

  int assertCount = 0;
  int failCount   = 0;
  int issueEdges  = 0;
  int issueBase;

  a25_copro_initiator dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_core_stall       (coreStall),
    .i_req_valid        (reqValid),
    .o_req_ready        (reqReady),
    .i_req_write        (reqWrite),
    .i_req_num          (reqNum),
    .i_req_crn          (reqCrn),
    .i_req_crm          (reqCrm),
    .i_req_opcode1      (reqOp1),
    .i_req_opcode2      (reqOp2),
    .i_req_wdata        (reqWdata),
    .o_rsp_valid        (rspValid),
    .i_rsp_ready        (rspReady),
    .o_rsp_rdata        (rspRdata),
    .o_rsp_err          (rspErr),
    .o_copro_operation  (copOp),
    .o_copro_num        (copNum),
    .o_copro_crn        (copCrn),
    .o_copro_crm        (copCrm),
    .o_copro_opcode1    (copOp1),
    .o_copro_opcode2    (copOp2),
    .o_copro_write_data (copWdata),
    .i_copro_read_data  (copRdata)
  );

  // Free-running core clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coprocessor register contents: crn 0 is the ID register, others encode crn.
  function automatic logic [31:0] coproModel(input logic [3:0] crn);
    if (crn == 4'd0) return 32'h4156_0300;
    return {16'hC0DE, 12'h000, crn};
  endfunction

  // Coprocessor read register, refreshed from the held crn on every non-stalled edge.
  always @(posedge clk) begin
    if (!rstN) copRdata <= 32'd0;
    else if (!coreStall) copRdata <= coproModel(copCrn);
  end

  // Counts edges where the coprocessor actually takes an operation.
  always @(posedge clk) begin
    if (rstN && !coreStall && copOp != 2'd0) issueEdges <= issueEdges + 1;
  end

  // Advance one clock and settle just after the active edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic wr, input logic [3:0] num, input logic [3:0] crn,
                        input logic [3:0] crm, input logic [2:0] o1, input logic [2:0] o2,
                        input logic [31:0] wd);
    reqWrite = wr; reqNum = num; reqCrn = crn; reqCrm = crm;
    reqOp1 = o1; reqOp2 = o2; reqWdata = wd;
  endtask

  task automatic test_reset;
    reqValid = 1'b1; rspReady = 1'b1;
    setReq(1'b1, 4'd15, 4'd6, 4'd6, 3'd1, 3'd1, 32'hFFFF_FFFF);
    tick; tick;
    assertCount++; if (reqReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", reqReady); end
    assertCount++; if (rspValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rspValid); end
    assertCount++; if (copOp !== 2'd0) begin failCount++; $display("[TB] FAIL reset_op: got %0d expected 0", copOp); end
    assertCount++; if (rspRdata !== 32'd0) begin failCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", rspRdata); end
    assertCount++; if (rspErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %b expected 0", rspErr); end
    assertCount++; if ({copNum, copCrn, copCrm, copOp1, copOp2} !== 18'd0) begin failCount++; $display("[TB] FAIL reset_fields: got %h expected 0", {copNum, copCrn, copCrm, copOp1, copOp2}); end
    assertCount++; if (copWdata !== 32'd0) begin failCount++; $display("[TB] FAIL reset_wdata: got %h expected 0", copWdata); end
    reqValid = 1'b0; rspReady = 1'b0;
    rstN = 1'b1;
    tick;
    assertCount++; if (reqReady !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_ready: got %b expected 1", reqReady); end
  endtask

  task automatic test_write;
    issueBase = issueEdges;
    setReq(1'b1, 4'd15, 4'd3, 4'd1, 3'd2, 3'd5, 32'h0000_00FF);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    assertCount++; if (copOp !== 2'd2) begin failCount++; $display("[TB] FAIL write_op: got %0d expected 2", copOp); end
    assertCount++; if (copCrn !== 4'd3) begin failCount++; $display("[TB] FAIL write_crn: got %0d expected 3", copCrn); end
    assertCount++; if (copWdata !== 32'h0000_00FF) begin failCount++; $display("[TB] FAIL write_data: got %h expected 000000ff", copWdata); end
    assertCount++; if ({copNum, copCrm, copOp1, copOp2} !== {4'd15, 4'd1, 3'd2, 3'd5}) begin failCount++; $display("[TB] FAIL write_fields: got %h expected %h", {copNum, copCrm, copOp1, copOp2}, {4'd15, 4'd1, 3'd2, 3'd5}); end
    assertCount++; if (reqReady !== 1'b0) begin failCount++; $display("[TB] FAIL write_ready_busy: got %b expected 0", reqReady); end
    assertCount++; if (rspValid !== 1'b0) begin failCount++; $display("[TB] FAIL write_early_rsp: got %b expected 0", rspValid); end
    tick;
    assertCount++; if (copOp !== 2'd0) begin failCount++; $display("[TB] FAIL write_op_one_cycle: got %0d expected 0", copOp); end
    assertCount++; if (rspValid !== 1'b1) begin failCount++; $display("[TB] FAIL write_rsp_valid: got %b expected 1", rspValid); end
    assertCount++; if ({rspErr, rspRdata} !== 33'd0) begin failCount++; $display("[TB] FAIL write_rsp_data: got %h expected 0", {rspErr, rspRdata}); end
    assertCount++; if (issueEdges - issueBase !== 1) begin failCount++; $display("[TB] FAIL write_issue_count: got %0d expected 1", issueEdges - issueBase); end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    assertCount++; if ({reqReady, rspValid, copOp} !== 4'b1000) begin failCount++; $display("[TB] FAIL write_back_idle: got %b expected 1000", {reqReady, rspValid, copOp}); end
    assertCount++; if (copCrn !== 4'd3) begin failCount++; $display("[TB] FAIL write_crn_hold: got %0d expected 3", copCrn); end
  endtask

  task automatic test_read_id;
    issueBase = issueEdges;
    setReq(1'b0, 4'd15, 4'd0, 4'd0, 3'd0, 3'd0, 32'hDEAD_BEEF);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    assertCount++; if (copOp !== 2'd1) begin failCount++; $display("[TB] FAIL read_op: got %0d expected 1", copOp); end
    tick;
    assertCount++; if (copOp !== 2'd0) begin failCount++; $display("[TB] FAIL read_capture_op: got %0d expected 0", copOp); end
    assertCount++; if (rspValid !== 1'b0) begin failCount++; $display("[TB] FAIL read_capture_rsp: got %b expected 0", rspValid); end
    assertCount++; if (copCrn !== 4'd0) begin failCount++; $display("[TB] FAIL read_capture_crn: got %0d expected 0", copCrn); end
    tick;
    assertCount++; if (rspValid !== 1'b1) begin failCount++; $display("[TB] FAIL read_rsp_valid: got %b expected 1", rspValid); end
    assertCount++; if (rspRdata !== 32'h4156_0300) begin failCount++; $display("[TB] FAIL read_id_data: got %h expected 41560300", rspRdata); end
    assertCount++; if (rspErr !== 1'b0) begin failCount++; $display("[TB] FAIL read_err: got %b expected 0", rspErr); end
    assertCount++; if (issueEdges - issueBase !== 1) begin failCount++; $display("[TB] FAIL read_issue_count: got %0d expected 1", issueEdges - issueBase); end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    assertCount++; if (reqReady !== 1'b1) begin failCount++; $display("[TB] FAIL read_back_idle: got %b expected 1", reqReady); end
  endtask

  task automatic test_stall;
    issueBase = issueEdges;
    setReq(1'b0, 4'd15, 4'd7, 4'd2, 3'd0, 3'd1, 32'd0);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    coreStall = 1'b1;
    reqCrn = 4'hA;
    for (int i = 0; i < 4; i++) begin
      assertCount++; if ({copOp, copCrn} !== {2'd1, 4'd7}) begin failCount++; $display("[TB] FAIL stall_hold_%0d: got %h expected 17", i, {copOp, copCrn}); end
      tick;
    end
    coreStall = 1'b0;
    assertCount++; if (copOp !== 2'd1) begin failCount++; $display("[TB] FAIL stall_op_fifth: got %0d expected 1", copOp); end
    tick;
    assertCount++; if ({copOp, rspValid} !== 3'b000) begin failCount++; $display("[TB] FAIL stall_capture: got %b expected 000", {copOp, rspValid}); end
    tick;
    assertCount++; if (rspValid !== 1'b1) begin failCount++; $display("[TB] FAIL stall_rsp_valid: got %b expected 1", rspValid); end
    assertCount++; if (rspRdata !== 32'hC0DE_0007) begin failCount++; $display("[TB] FAIL stall_rdata: got %h expected c0de0007", rspRdata); end
    assertCount++; if (issueEdges - issueBase !== 1) begin failCount++; $display("[TB] FAIL stall_issue_count: got %0d expected 1", issueEdges - issueBase); end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
  endtask

  task automatic test_bad_num;
    issueBase = issueEdges;
    setReq(1'b0, 4'd14, 4'd4, 4'd0, 3'd0, 3'd0, 32'd0);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    assertCount++; if (copOp !== 2'd0) begin failCount++; $display("[TB] FAIL bad_op: got %0d expected 0", copOp); end
    assertCount++; if (rspValid !== 1'b1) begin failCount++; $display("[TB] FAIL bad_rsp_valid: got %b expected 1", rspValid); end
    assertCount++; if (rspErr !== 1'b1) begin failCount++; $display("[TB] FAIL bad_err: got %b expected 1", rspErr); end
    assertCount++; if (rspRdata !== 32'd0) begin failCount++; $display("[TB] FAIL bad_rdata: got %h expected 0", rspRdata); end
    assertCount++; if (reqReady !== 1'b0) begin failCount++; $display("[TB] FAIL bad_ready: got %b expected 0", reqReady); end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
    assertCount++; if ({reqReady, copOp} !== 3'b100) begin failCount++; $display("[TB] FAIL bad_back_idle: got %b expected 100", {reqReady, copOp}); end
    assertCount++; if (issueEdges - issueBase !== 0) begin failCount++; $display("[TB] FAIL bad_issue_count: got %0d expected 0", issueEdges - issueBase); end
  endtask

  task automatic test_back_to_back;
    setReq(1'b0, 4'd15, 4'd5, 4'd0, 3'd0, 3'd0, 32'd0);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    tick; tick;
    assertCount++; if ({rspValid, rspRdata} !== {1'b1, 32'hC0DE_0005}) begin failCount++; $display("[TB] FAIL bp_first_rsp: got %h expected 1c0de0005", {rspValid, rspRdata}); end
    for (int i = 0; i < 3; i++) begin
      tick;
      assertCount++; if ({rspValid, reqReady, rspErr, rspRdata} !== {3'b100, 32'hC0DE_0005}) begin failCount++; $display("[TB] FAIL bp_hold_%0d: got %h expected %h", i, {rspValid, reqReady, rspErr, rspRdata}, {3'b100, 32'hC0DE_0005}); end
    end
    rspReady = 1'b1;
    reqValid = 1'b1;
    setReq(1'b1, 4'd15, 4'd9, 4'd0, 3'd0, 3'd0, 32'h1234_5678);
    tick;
    rspReady = 1'b0;
    assertCount++; if ({rspValid, reqReady, copOp} !== 4'b0100) begin failCount++; $display("[TB] FAIL bp_release_no_accept: got %b expected 0100", {rspValid, reqReady, copOp}); end
    tick;
    reqValid = 1'b0;
    assertCount++; if ({copOp, copCrn} !== {2'd2, 4'd9}) begin failCount++; $display("[TB] FAIL bp_next_accept: got %h expected 29", {copOp, copCrn}); end
    assertCount++; if (copWdata !== 32'h1234_5678) begin failCount++; $display("[TB] FAIL bp_next_wdata: got %h expected 12345678", copWdata); end
    tick;
    assertCount++; if ({rspValid, rspRdata} !== {1'b1, 32'd0}) begin failCount++; $display("[TB] FAIL bp_next_rsp: got %h expected 100000000", {rspValid, rspRdata}); end
    rspReady = 1'b1;
    tick;
    rspReady = 1'b0;
  endtask

  task automatic test_reset_stall;
    issueBase = issueEdges;
    setReq(1'b0, 4'd15, 4'd2, 4'd3, 3'd1, 3'd2, 32'd0);
    reqValid = 1'b1;
    tick;
    reqValid = 1'b0;
    coreStall = 1'b1;
    tick; tick;
    assertCount++; if (copOp !== 2'd1) begin failCount++; $display("[TB] FAIL rst_stall_pre_op: got %0d expected 1", copOp); end
    rstN = 1'b0;
    tick;
    assertCount++; if ({copOp, reqReady, rspValid} !== 4'b0010) begin failCount++; $display("[TB] FAIL rst_stall_abort: got %b expected 0010", {copOp, reqReady, rspValid}); end
    assertCount++; if (copCrn !== 4'd0) begin failCount++; $display("[TB] FAIL rst_stall_crn: got %0d expected 0", copCrn); end
    rstN = 1'b1;
    coreStall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      assertCount++; if ({rspValid, copOp} !== 3'b000) begin failCount++; $display("[TB] FAIL rst_stall_no_rsp_%0d: got %b expected 000", i, {rspValid, copOp}); end
    end
    assertCount++; if (issueEdges - issueBase !== 0) begin failCount++; $display("[TB] FAIL rst_stall_issue_count: got %0d expected 0", issueEdges - issueBase); end
  endtask

  // Scenario sequencer.
  initial begin
    rstN = 1'b0; coreStall = 1'b0; reqValid = 1'b0; rspReady = 1'b0;
    setReq(1'b0, 4'd0, 4'd0, 4'd0, 3'd0, 3'd0, 32'd0);
    test_reset;
    test_write;
    test_read_id;
    test_stall;
    test_bad_num;
    test_back_to_back;
    test_reset_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/a25_copro_initiator.md
A25_COPRO_INITIATOR -- requirements
Module: a25_copro_initiator

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-002 i_clk  input  1  core clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  synchronous active-low reset.
REQ-004 i_core_stall  input  1  core stall; while it is high, the coprocessor samples nothing.
REQ-005 i_req_valid  input  1  request present.
REQ-006 o_req_ready  output  1  block can accept a request.
REQ-007 i_req_write  input  1  1 = MCR (write), 0 = MRC (read).
REQ-008 i_req_num  input  4  coprocessor number.
REQ-009 i_req_crn, i_req_crm  input  4 each  register numbers.
REQ-010 i_req_opcode1, i_req_opcode2  input  3 each  opcodes.
REQ-011 i_req_wdata  input  32  write data.
REQ-012 o_rsp_valid  output  1  response present.
REQ-013 i_rsp_ready  input  1  response consumer ready.
REQ-014 o_rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-015 o_rsp_err  output  1  request targeted a coprocessor other than 15.
REQ-016 o_copro_operation  output  2  0 = idle, 1 = read, 2 = write.
REQ-017 o_copro_num, o_copro_crn, o_copro_crm  output  4 each  fields driven to the coprocessor.
REQ-018 o_copro_opcode1, o_copro_opcode2  output  3 each  opcodes driven to the coprocessor.
REQ-019 o_copro_write_data  output  32  data driven to the coprocessor.
REQ-020 i_copro_read_data  input  32  coprocessor read register; it is updated on every non-stalled edge from the crn held at that edge.

Function
REQ-021 The state machine SHALL have four states: IDLE, ISSUE, CAPTURE and RESP.
REQ-022 o_req_ready SHALL be 1 only in IDLE.
REQ-023 A request SHALL be accepted on an edge in IDLE where i_req_valid = 1.
REQ-024 On acceptance, all request fields SHALL be latched into internal registers.
REQ-025 On acceptance with i_req_num = 15, the next state SHALL be ISSUE.
REQ-026 On acceptance with i_req_num != 15, the next state SHALL be RESP with o_rsp_err = 1 and rdata = 0, and no coprocessor operation SHALL be driven.
REQ-027 In ISSUE, o_copro_operation SHALL be 1 for a read or 2 for a write, and o_copro_* SHALL reflect the latched fields.
REQ-028 ISSUE SHALL be held for as long as i_core_stall = 1.
REQ-029 The first edge in ISSUE with i_core_stall = 0 SHALL complete the issue; each request SHALL be issued exactly once, so exactly one non-stalled edge sees a non-zero operation.
REQ-030 When a write issue completes, the next state SHALL be RESP with rdata = 0 and err = 0.
REQ-031 When a read issue completes, the next state SHALL be CAPTURE.
REQ-032 In CAPTURE, o_copro_operation SHALL be 0, and o_copro_crn/crm/num SHALL remain at the latched values so the read register stays valid.
REQ-033 The CAPTURE edge SHALL latch i_copro_read_data into o_rsp_rdata with err = 0, and the next state SHALL be RESP; this edge SHALL occur regardless of i_core_stall.
REQ-034 Read latency with no stall SHALL be 3 edges from acceptance to o_rsp_valid (accept, issue, capture).
REQ-035 In RESP, o_rsp_valid SHALL be 1, and o_rsp_rdata and o_rsp_err SHALL be stable until i_rsp_ready = 1.
REQ-036 An edge in RESP with i_rsp_ready = 1 SHALL return the state to IDLE; there SHALL be no accept in that same cycle, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-037 In IDLE and RESP, o_copro_operation SHALL be 0; the other o_copro_* outputs SHALL hold their last latched values.
REQ-038 i_req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-039 When i_rst_n = 0 at an edge, the state SHALL become IDLE regardless of the current state, including mid-ISSUE under stall.
REQ-040 After reset, o_copro_operation = 0, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, all o_copro_* fields = 0, o_copro_write_data = 0 and o_req_ready = 1.
REQ-041 Reset SHALL override i_req_valid and i_rsp_ready in the same cycle.

Verification
REQ-042 Write, no stall: num = 15, crn = 3, wdata = 0x0000_00FF -> operation = 2 for exactly 1 cycle with crn = 3 and write_data = 0xFF; rsp_valid on the 2nd edge after accept with rdata = 0 and err = 0.
REQ-043 Read ID: num = 15, crn = 0, coprocessor model returns 0x4156_0300 -> operation = 1 for 1 cycle; rsp_valid with rdata = 0x4156_0300 three edges after accept.
REQ-044 Stall during ISSUE: read of crn = 7 with i_core_stall high for 4 cycles -> operation = 1 held for 5 cycles and sampled once; rdata equals the model's crn 7 value.
REQ-045 Bad coprocessor: num = 14 -> operation stays 0 throughout; rsp_valid on the next edge with err = 1 and rdata = 0.
REQ-046 Backpressure: i_rsp_ready low for 3 cycles -> rsp_valid and rdata are held stable and o_req_ready = 0; release -> IDLE, and a new request is accepted one cycle later.
REQ-047 Reset while ISSUE is stalled -> next cycle operation = 0, state IDLE, rsp_valid = 0, and no response is ever produced for the aborted request.
